// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial wide adder sequencer: drives an external 4-bit slice LSB first and assembles the sum.
// Optional subtract mode (sub port, A - B in two's complement) is enabled with `define NIBBLE_ADDER_SUB_EN.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
`ifdef NIBBLE_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_f,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES <= 2) ? 1 : $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [W-1:0]  r_sum;
  logic          r_cout;

  logic [W-1:0]  w_b_in;
  logic          w_c_in;
  logic          w_last;

`ifdef NIBBLE_ADDER_SUB_EN
  assign w_b_in = sub ? ~op_b : op_b;
  assign w_c_in = sub ? 1'b1  : cin;
`else
  assign w_b_in = op_b;
  assign w_c_in = cin;
`endif

  assign w_last = (r_idx == IW'(NIBBLES - 1));

  // Operands shift right each RUN cycle so the slice inputs come straight from
  // register bits, and drain to zero by the time the run completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= add_f;
          r_a <= r_a >> 4;
          r_b <= r_b >> 4;
          if (w_last) begin
            r_cout  <= add_cout;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_carry <= add_cout;
            r_idx   <= r_idx + IW'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign add_a   = r_a[3:0];
  assign add_b   = r_b[3:0];
  assign add_cin = r_carry;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign sum     = r_sum;
  assign cout    = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl; models the 4-bit slice and predicts results arithmetically.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         sub;
  logic [3:0]   add_a, add_b, add_f;
  logic         add_cin, add_cout;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // The combinational slice the controller drives.
  assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef NIBBLE_ADDER_SUB_EN
    .sub      (sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_f    (add_f),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'd0);
    chk({tag, "_cout"}, 64'(cout), 64'd0);
    chk({tag, "_add"}, 64'({add_a, add_b, add_cin}), 64'd0);
  endtask

  // One complete operation. With hold=1 start stays high and the operands are
  // scrambled while busy; the result must still use the values latched at start.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic hold);
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic [W-1:0] b_eff;
    if (s) begin
      exp_sum  = a - b;
      exp_cout = (a >= b);
      b_eff    = ~b;
    end else begin
      {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      b_eff    = b;
    end
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    else begin
      op_a = W'($urandom); op_b = W'($urandom); cin = ~c; sub = ~s;
    end
    for (int k = 0; k < N; k++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_nodone"}, 64'(done), 64'd0);
      chk({tag, "_add_a"}, 64'(add_a), 64'((a >> (4 * k)) & 'hF));
      chk({tag, "_add_b"}, 64'(add_b), 64'((b_eff >> (4 * k)) & 'hF));
      step();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_dn"}, 64'(busy), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    step();
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_held_sum"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      step();
      chk_all_zero("rst");
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_a = W'($urandom); op_b = W'($urandom);
      step();
      chk_all_zero("idle");
    end

    run_op("ex1", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
    run_op("wrap_b", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("wrap_c", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Start held high: the second op is accepted only from IDLE
    run_op("hold1", 16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b1);
    op_a = 16'h0F0F; op_b = 16'h00F1; cin = 1'b1; sub = 1'b0;
    run_op("hold2", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0);

    // Reset during RUN cycle 2 aborts with no done
    op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      step();
      chk("abort_nodone", 64'(done), 64'd0);
      chk("abort_nobusy", 64'(busy), 64'd0);
    end
    run_op("after_abort", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);

`ifdef NIBBLE_ADDER_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    run_op("sub_cin", 16'h1000, 16'h1000, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      logic s;
`ifdef NIBBLE_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), s, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs wide additions one nibble per clock using the team's existing combinational 4-bit ripple adder slice (A/B/C0 in, F/C4 out).
- Latches two NIBBLES×4-bit operands plus carry-in, drives the slice LSB nibble first, chains the carry through a register and assembles the wide sum.
- Sits directly upstream of the slice and consumes its result; exposes a start/busy/done handshake to the surrounding datapath.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an operation; sampled only in IDLE
- op_a  input  W  operand A, latched on accepted start
- op_b  input  W  operand B, latched on accepted start
- cin  input  1  initial carry-in, latched on accepted start
- add_a  output  4  to slice A: current nibble of latched A
- add_b  output  4  to slice B: current nibble of latched B
- add_cin  output  1  to slice C0: chained carry register
- add_f  input  4  from slice F
- add_cout  input  1  from slice C4
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- sum  output  W  assembled result; held until next accepted start
- cout  output  1  final carry-out; held until next accepted start

Behaviour:
- Clocking and reset: single clock domain, clk. rst_n is asynchronous and active-low. While rst_n is low:
  - state = IDLE; nibble index, operand registers and carry register are cleared to 0;
  - sum = 0, cout = 0, busy = 0, done = 0;
  - add_a = add_b = 0 and add_cin = 0.
- Reset asserted mid-operation aborts immediately. No partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0; add_* outputs driven 0.
  - start = 1 → latch op_a, op_b, cin into carry register; clear sum and cout; index = 0; next state RUN.
- RUN (busy = 1):
  - add_a and add_b are the nibble [4*idx+3 : 4*idx] of the latched operands; add_cin is the carry register. All three are purely registered, so the slice sees stable inputs for the whole cycle.
  - At each clock edge: add_f is written into the sum nibble idx, the carry register loads add_cout, and idx increments.
  - When idx = NIBBLES-1 at the edge: cout loads add_cout and the next state is DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - done = 1 for exactly one cycle, busy = 0; sum and cout are valid. Next state IDLE unconditionally.
- Latency: start sampled at edge 0 → done high during the cycle after edge NIBBLES. The next start is accepted at edge NIBBLES+2 at the earliest.
- start is ignored in RUN and DONE. There is no queuing, and operand changes while busy have no effect.
- Arithmetic is modulo 2^W with carry out on cout. Example: all-ones + 1 gives sum = 0, cout = 1.
- sum nibbles are written progressively during RUN. Consumers must qualify sum and cout with done (or with busy low after done).

Optional Feature:
- Macro: NIBBLE_ADDER_SUB_EN
- Defined:
  - Extra input port sub (1 bit), latched on accepted start.
  - When latched sub = 1: operand B is latched as its bitwise inverse, and the carry register is initialised to 1, ignoring cin. The result is then A − B in two's complement.
  - cout = 1 means no borrow (A ≥ B unsigned).
- Not defined: no sub port; addition only, with the behaviour above.

Test Plan:
- Reset: rst_n low with random inputs → sum = 0, cout = 0, busy = 0, done = 0, add_* = 0; release and stay idle with no start → nothing changes.
- NIBBLES = 4, op_a = 0x1234, op_b = 0x0FCD, cin = 0, start pulse → busy for 4 cycles, done pulse in the 5th cycle, sum = 0x2201, cout = 0; add_a sequence 4, 3, 2, 1.
- op_a = 0xFFFF, op_b = 0x0001, cin = 0 → sum = 0x0000, cout = 1. Repeat with op_b = 0x0000 and cin = 1 → same result.
- Start held high through the whole operation, and operands changed while busy → exactly one operation, using the originally latched operands. A second operation starts only from IDLE, two cycles after the first done.
- Reset pulsed low during RUN cycle 2 of a 0xFFFF + 0x0001 add → outputs return to 0 at once; no done pulse follows; a fresh start afterwards completes correctly.
- With NIBBLE_ADDER_SUB_EN: 0x0005 − 0x0007 (sub = 1) → sum = 0xFFFE, cout = 0. Then 0x0007 − 0x0005 → sum = 0x0002, cout = 1.
